// File: rtl/sreg_pkg.sv
// Shared types and helpers for the framed serial shifter.
// Used by sreg_core and sreg_frame.
package sreg_pkg;

    localparam int DWIDTH_DEF = 21;

    // Widest word the shift helper handles.
    localparam int MAXW = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // One serial step. A word narrower than MAXW is passed in
    // zero-extended. In LSB-first mode the new bit lands in bit width-1.
    function automatic logic [MAXW-1:0] shift_word(
        input logic [MAXW-1:0] w,
        input int              width,
        input logic            msb_first,
        input logic            sin
    );
        logic [MAXW-1:0] r;
        if (msb_first) begin
            r = {w[MAXW-2:0], sin};
        end else begin
            r = w >> 1;
            for (int i = 0; i < MAXW; i++)
                if (i == width - 1) r[i] = sin;
        end
        return r;
    endfunction

endpackage

// File: rtl/sreg_core.sv
// Shift register with parallel load, enable and bit order.
// Load takes priority over shift; nxt is the post-shift value.
module sreg_core
    import sreg_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic              sin,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] nxt,
    output logic              sout
);

    logic [DWIDTH-1:0] q;

    assign nxt = DWIDTH'(shift_word(MAXW'(q), DWIDTH,
                                    MSB_FIRST, sin));

    assign sout = MSB_FIRST ? q[DWIDTH-1] : q[0];

    // Word register: clear, reload, or take one serial bit.
    always_ff @(posedge clk) begin
        if (reset)      q <= '0;
        else if (load)  q <= din;
        else if (shift) q <= nxt;
    end

endmodule

// File: rtl/sreg_frame.sv
// Framed bidirectional serial shifter for the MCU-to-cart link.
// FSM, bit counter and received-word outputs around sreg_core.
module sreg_frame
    import sreg_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame,
    input  logic              shift_en,
    input  logic              sin,
    output logic              sout,
    input  logic [DWIDTH-1:0] tx_data,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    output logic              short_frame,
    output logic              busy
);

    localparam int CNT_W = $clog2(DWIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWIDTH - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              load;
    logic              shift;
    logic              last;
    logic [DWIDTH-1:0] nxt;

    assign last = (cnt == LAST);
    assign busy = (state == ACTIVE);

    // Core strobes: load at frame start and at each word boundary.
    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        unique case (1'b1)
            state == IDLE: begin
                load = frame;
            end
            state == ACTIVE: begin
                shift = frame & shift_en;
                load  = frame & shift_en & last;
            end
        endcase
    end

    sreg_core #(
        .DWIDTH    (DWIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .sin   (sin),
        .din   (tx_data),
        .nxt   (nxt),
        .sout  (sout)
    );

    // Frame FSM, bit count and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            short_frame <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                    end
                end
                ACTIVE: begin
                    if (!frame) begin
                        state       <= IDLE;
                        short_frame <= (cnt != '0);
                        cnt         <= '0;
                    end else if (shift_en) begin
                        if (last) begin
                            cnt      <= '0;
                            rx_data  <= nxt;
                            rx_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sreg_frame.sv
// Self-checking bench for sreg_frame, both bit orders side by side.
// Both DUTs see the same pins; a bit-queue model predicts each one.
module tb_sreg_frame;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame;
    logic         shift_en;
    logic         sin;
    logic [W-1:0] tx_data;

    logic         sout_m, sout_l;
    logic [W-1:0] rx_m, rx_l;
    logic         rxv_m, rxv_l;
    logic         shf_m, shf_l;
    logic         busy_m, busy_l;

    int checks   = 0;
    int failures = 0;

    // model: last complete word seen by each DUT
    logic [W-1:0] exp_m = '0;
    logic [W-1:0] exp_l = '0;

    // scenario inputs for test_frame_words
    logic [W-1:0] txw [4];
    logic [W-1:0] bw  [4];

    always #5 clk = ~clk;

    sreg_frame #(.DWIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .frame(frame),
        .shift_en(shift_en), .sin(sin), .sout(sout_m),
        .tx_data(tx_data), .rx_data(rx_m), .rx_valid(rxv_m),
        .short_frame(shf_m), .busy(busy_m)
    );

    sreg_frame #(.DWIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .frame(frame),
        .shift_en(shift_en), .sin(sin), .sout(sout_l),
        .tx_data(tx_data), .rx_data(rx_l), .rx_valid(rxv_l),
        .short_frame(shf_l), .busy(busy_l)
    );

    // i-th received bit goes to the first-bit end for that order
    function automatic logic [W-1:0] assemble(
        input logic q[$], input bit msb);
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++)
            if (msb) r[W-1-i] = q[i];
            else     r[i]     = q[i];
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({sout_m, sout_l, busy_m, busy_l, rxv_m, rxv_l,
             shf_m, shf_l} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got %b want 00000000",
                {sout_m, sout_l, busy_m, busy_l,
                 rxv_m, rxv_l, shf_m, shf_l});
        end
        checks++;
        if (rx_m !== '0 || rx_l !== '0) begin
            failures++;
            $display("FAIL reset_rx got %h/%h want 0/0", rx_m, rx_l);
        end
    endtask

    task automatic test_idle_shift();
        for (int k = 0; k < 5; k++) begin
            frame    = 1'b0;
            shift_en = 1'b1;
            sin      = 1'($urandom);
            tx_data  = W'($urandom);
            @(negedge clk);
            shift_en = 1'b0;
            @(negedge clk);
            checks++;
            if ({sout_m, sout_l, busy_m, busy_l, rxv_m, rxv_l,
                 shf_m, shf_l} !== 8'h00 ||
                rx_m !== exp_m || rx_l !== exp_l) begin
                failures++;
                $display("FAIL idle_shift%0d got %b %h %h want 0 %h %h",
                    k, {sout_m, sout_l, busy_m, busy_l, rxv_m,
                        rxv_l, shf_m, shf_l}, rx_m, rx_l,
                    exp_m, exp_l);
            end
        end
    endtask

    // n words in one frame; word j uses txw[j] and sends bw[j]
    // MSB-first (msb_order=1) or LSB-first (msb_order=0).
    task automatic test_frame_words(input int n, input bit msb_order);
        logic q[$];
        logic b;
        frame    = 1'b1;
        shift_en = 1'b0;
        tx_data  = txw[0];
        @(negedge clk);
        tx_data = W'($urandom);
        checks++;
        if (busy_m !== 1'b1 || busy_l !== 1'b1) begin
            failures++;
            $display("FAIL busy_start got %b%b want 11", busy_m, busy_l);
        end
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < W; i++) begin
                checks++;
                if (sout_m !== txw[j][W-1-i] || sout_l !== txw[j][i]) begin
                    failures++;
                    $display("FAIL sout w%0d b%0d got %b%b want %b%b",
                        j, i, sout_m, sout_l, txw[j][W-1-i], txw[j][i]);
                end
                if (i == W-1)
                    tx_data = (j + 1 < n) ? txw[j+1] : W'($urandom);
                b = msb_order ? bw[j][W-1-i] : bw[j][i];
                q.push_back(b);
                shift_en = 1'b1;
                sin      = b;
                @(negedge clk);
                shift_en = 1'b0;
                sin      = 1'($urandom);
                tx_data  = W'($urandom);
                if (i == W-1) begin
                    exp_m = assemble(q, 1'b1);
                    exp_l = assemble(q, 1'b0);
                    q.delete();
                    checks++;
                    if (rxv_m !== 1'b1 || rxv_l !== 1'b1 ||
                        rx_m !== exp_m || rx_l !== exp_l) begin
                        failures++;
                        $display("FAIL word%0d got v%b%b %h %h want v11 %h %h",
                            j, rxv_m, rxv_l, rx_m, rx_l, exp_m, exp_l);
                    end
                    @(negedge clk);
                    checks++;
                    if (rxv_m !== 1'b0 || rxv_l !== 1'b0 ||
                        rx_m !== exp_m || rx_l !== exp_l) begin
                        failures++;
                        $display("FAIL word%0d_hold got v%b%b %h %h want v00 %h %h",
                            j, rxv_m, rxv_l, rx_m, rx_l, exp_m, exp_l);
                    end
                end else begin
                    checks++;
                    if (rxv_m !== 1'b0 || rxv_l !== 1'b0) begin
                        failures++;
                        $display("FAIL early_valid w%0d b%0d got %b%b want 00",
                            j, i, rxv_m, rxv_l);
                    end
                end
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end
        frame = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_m, busy_l, shf_m, shf_l, rxv_m, rxv_l} !== 6'b0) begin
            failures++;
            $display("FAIL clean_end got %b want 000000",
                {busy_m, busy_l, shf_m, shf_l, rxv_m, rxv_l});
        end
    endtask

    // nstr strobes then frame drop; coinc puts a strobe on the drop.
    task automatic test_short_frame(input int nstr, input bit coinc);
        logic want;
        want     = (nstr != 0);
        frame    = 1'b1;
        shift_en = 1'b0;
        tx_data  = W'($urandom);
        @(negedge clk);
        for (int i = 0; i < nstr; i++) begin
            shift_en = 1'b1;
            sin      = 1'($urandom);
            @(negedge clk);
            shift_en = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        frame    = 1'b0;
        shift_en = coinc;
        sin      = 1'($urandom);
        @(negedge clk);
        shift_en = 1'b0;
        checks++;
        if (shf_m !== want || shf_l !== want ||
            rxv_m !== 1'b0 || rxv_l !== 1'b0 ||
            busy_m !== 1'b0 || busy_l !== 1'b0) begin
            failures++;
            $display("FAIL short%0d_%0d got s%b%b v%b%b b%b%b want s%b%b v00 b00",
                nstr, coinc, shf_m, shf_l, rxv_m, rxv_l,
                busy_m, busy_l, want, want);
        end
        checks++;
        if (rx_m !== exp_m || rx_l !== exp_l) begin
            failures++;
            $display("FAIL short%0d_rx got %h %h want %h %h",
                nstr, rx_m, rx_l, exp_m, exp_l);
        end
        @(negedge clk);
        checks++;
        if (shf_m !== 1'b0 || shf_l !== 1'b0) begin
            failures++;
            $display("FAIL short%0d_pulse got %b%b want 00",
                nstr, shf_m, shf_l);
        end
    endtask

    task automatic test_reset_midword();
        frame    = 1'b1;
        shift_en = 1'b0;
        tx_data  = W'($urandom);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            shift_en = 1'b1;
            sin      = 1'($urandom);
            @(negedge clk);
            shift_en = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame = 1'b0;
        exp_m = '0;
        exp_l = '0;
        checks++;
        if ({sout_m, sout_l, busy_m, busy_l, rxv_m, rxv_l,
             shf_m, shf_l} !== 8'h00 ||
            rx_m !== '0 || rx_l !== '0) begin
            failures++;
            $display("FAIL reset_mid got %b %h %h want 00000000 0 0",
                {sout_m, sout_l, busy_m, busy_l, rxv_m, rxv_l,
                 shf_m, shf_l}, rx_m, rx_l);
        end
        @(negedge clk);
        checks++;
        if (shf_m !== 1'b0 || shf_l !== 1'b0 ||
            rxv_m !== 1'b0 || rxv_l !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got s%b%b v%b%b want s00 v00",
                shf_m, shf_l, rxv_m, rxv_l);
        end
    endtask

    initial begin
        reset    = 1'b1;
        frame    = 1'b0;
        shift_en = 1'b0;
        sin      = 1'b0;
        tx_data  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_idle_shift();

        txw[0] = 21'h0F0F0;
        bw[0]  = 21'h12345;
        test_frame_words(1, 1'b1);
        test_frame_words(1, 1'b0);

        txw[0] = 21'h15A5A;
        txw[1] = 21'h0C3C3;
        bw[0]  = 21'h00001;
        bw[1]  = 21'h1FFFFF;
        test_frame_words(2, 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                txw[k] = W'($urandom);
                bw[k]  = W'($urandom);
            end
            test_frame_words(r + 2, 1'(r));
        end

        test_short_frame(7, 1'b0);
        test_short_frame(20, 1'b1);
        test_short_frame(0, 1'b0);

        test_reset_midword();
        txw[0] = W'($urandom);
        bw[0]  = W'($urandom);
        test_frame_words(1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sreg_frame.md
Name: sreg_frame

Overview:
- Parametrised successor to the plain serial-in shift register.
- Framed, bidirectional serial shifter for the CPLD's MCU-to-cart link: deserialises words of DWIDTH bits on a frame strobe and serialises a parallel load word out at the same time.
- Adds reset, shift enable, MSB/LSB-first ordering, bit counting, a word-valid strobe and short-frame detection.
- Sits between the MCU serial pins (already synchronised to clk) and the address/command registers.

Parameters:
- DWIDTH, 21, word width in bits (>=2).
- MSB_FIRST, 1, 1 = shift toward MSB (first bit ends in bit DWIDTH-1); 0 = LSB-first.
- CNT_W, $clog2(DWIDTH), localparam, bit-counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- frame  in  1  word-frame select, active high, synchronous to clk.
- shift_en  in  1  one-cycle strobe per serial bit; sample sin, advance sout.
- sin  in  1  serial data in.
- sout  out  1  serial data out; current outgoing bit.
- tx_data  in  DWIDTH  parallel word to transmit; captured at frame start and at each word boundary.
- rx_data  out  DWIDTH  last complete received word; held until the next complete word.
- rx_valid  out  1  one-cycle pulse; rx_data updated.
- short_frame  out  1  one-cycle pulse; frame ended with a partial word.
- busy  out  1  high while state is ACTIVE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset values: shreg=0, cnt=0, rx_data=0, rx_valid=0, short_frame=0, state=IDLE. Therefore sout=0 and busy=0.
- Reset asserted mid-frame aborts the frame silently: no rx_valid, no short_frame.
- States:
  - IDLE: when frame=1, load shreg<=tx_data, cnt<=0, go to ACTIVE. shift_en is ignored in this cycle.
  - ACTIVE, frame=1 and shift_en=1:
    - MSB_FIRST=1: shreg<={shreg[DWIDTH-2:0],sin}.
    - MSB_FIRST=0: shreg<={sin,shreg[DWIDTH-1:1]}.
    - cnt<=cnt+1.
  - ACTIVE, frame=1 and shift_en=1 with cnt==DWIDTH-1 (word boundary):
    - rx_data<=the shifted value (including this sin).
    - rx_valid<=1 for the next cycle only.
    - cnt<=0 and shreg<=tx_data (reload), so back-to-back words continue in one frame.
  - ACTIVE, frame=0:
    - Go to IDLE.
    - If cnt!=0: short_frame pulses 1 cycle, the partial word is discarded, rx_data is unchanged.
    - If cnt==0: clean end, no pulse.
- sout is combinational from the register: shreg[DWIDTH-1] if MSB_FIRST, else shreg[0]. It is valid from the cycle after frame start and changes only after a shift_en cycle.
- Latency: rx_valid and the new rx_data are visible 1 cycle after the clk edge that samples the final bit.
- Simultaneous events:
  - frame=0 with shift_en=1: frame wins; the shift is ignored. If cnt==DWIDTH-1, the word is incomplete → short_frame.
  - Frame drop in the cycle after a word boundary: cnt==0, so clean end.
- shift_en while IDLE: no effect.
- rx_valid and short_frame are never high in the same cycle.

Decomposition:
- Package sreg_pkg:
  - State enum (IDLE, ACTIVE).
  - Helper function for the bit-order-dependent shift.
  - Default DWIDTH constant (21).
- One natural sub-module, sreg_core: DWIDTH register with parallel load, enable and MSB/LSB direction, exposing sout. The FSM, counter and output registers stay in sreg_frame.

Test Plan:
- Reset mid-word: reset=1 after 10 shifts of a frame → next cycle rx_data=0, busy=0, no short_frame and no rx_valid pulse; a following fresh frame works normally.
- MSB_FIRST=1, DWIDTH=21, tx_data=21'h0F0F0:
  - Stimulus: frame high, 21 shift_en strobes carrying 21'h12345 MSB-first.
  - Response: rx_data=21'h12345 with rx_valid high exactly 1 cycle, one cycle after the 21st strobe.
  - Response: sout sequence = bits 20..0 of 21'h0F0F0.
- MSB_FIRST=0:
  - Stimulus: same stimulus, bits sent LSB-first.
  - Response: rx_data=21'h12345.
  - Response: sout = bits 0..20 of tx_data.
- Back-to-back words: frame held for 42 strobes with words 21'h00001 then 21'h1FFFFF.
  - Response: two rx_valid pulses, rx_data sequence matches.
  - Response: tx_data is reloaded at the boundary, so sout restarts with the new tx_data MSB.
- Short frame: frame drops after 7 strobes → short_frame 1 cycle, rx_data keeps its previous value, busy=0.
- Simultaneous event: frame=0 coincident with the 21st shift_en → short_frame pulses, no rx_valid.
- Stray shift_en while IDLE: 5 strobes with frame low → no output change.
